// File: rtl/spi_ram_arb_pkg.sv
// Shared types for the SPI/host RAM arbiter.
// Commands are {opcode[1:0], payload[7:0]}.
package spi_ram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPI_ISSUE,
    S_SPI_LOCK,
    S_SPI_RD_WAIT,
    S_H_ADDR,
    S_H_DATA,
    S_H_RD_WAIT
  } state_t;

  typedef enum logic {
    OWN_SPI,
    OWN_HOST
  } owner_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic [9:0] mk_cmd(
    input logic [1:0] op,
    input logic [7:0] pl
  );
    return {op, pl};
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_capture.sv
// SPI command capture: rising-edge detect on the valid level,
// one-entry buffer, sticky overwrite flag.
module spi_cmd_capture
  import spi_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [9:0] i_data,
  input  logic       i_pop,
  output logic       o_pend,
  output logic [9:0] o_data,
  output logic       o_ovf
);

  logic       r_prev;
  logic       r_pend;
  logic       r_ovf;
  logic [9:0] r_data;
  logic       w_load;

  assign w_load = i_valid & ~r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
      r_data <= '0;
    end else begin
      r_prev <= i_valid;
      if (w_load) begin
        r_data <= i_data;
        r_pend <= 1'b1;
        // a pop in the same cycle means the old entry was consumed
        if (r_pend && !i_pop)
          r_ovf <= 1'b1;
      end else if (i_pop) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_data = r_data;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares the single-port RAM between the SPI command stream
// and a host port; host accesses go out as atomic pairs.
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE    = 8,
  parameter int MEM_WIDTH    = 8,
  parameter int LOCK_TIMEOUT = 64,
  parameter int RD_TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           spi_rx_data,
  input  logic                 spi_rx_valid,
  input  logic                 spi_ss_n,
  output logic [MEM_WIDTH-1:0] spi_tx_data,
  output logic                 spi_tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [MEM_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [MEM_WIDTH-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 err_ovf,
  output logic                 err_timeout
);

  localparam int TMAX =
    (LOCK_TIMEOUT > RD_TIMEOUT) ? LOCK_TIMEOUT : RD_TIMEOUT;
  localparam int TW = $clog2(TMAX) + 1;

  state_t                 r_state, w_next;
  owner_t                 r_owner, w_owner_nx;
  logic                   r_lock, w_lock_nx;
  logic [TW-1:0]          r_timer, w_timer_nx;
  logic                   r_we;
  logic [MEM_WIDTH-1:0]   r_wdata;
  logic [MEM_WIDTH-1:0]   r_spi_tx_data;
  logic                   r_spi_tx_valid;
  logic [MEM_WIDTH-1:0]   r_host_rdata;
  logic                   r_host_rvalid;
  logic                   r_err_to;

  logic       w_pend;
  logic [9:0] w_buf;
  logic       w_pop;
  logic [9:0] w_din;
  logic       w_vld;
  logic       w_gnt;
  logic       w_spi_cap;
  logic       w_host_cap;
  logic       w_to;
  logic       w_host_win;

  spi_cmd_capture u_cap (
    .clk     (clk),
    .rst     (rst),
    .i_valid (spi_rx_valid),
    .i_data  (spi_rx_data),
    .i_pop   (w_pop),
    .o_pend  (w_pend),
    .o_data  (w_buf),
    .o_ovf   (err_ovf)
  );

  // host wins ties right after an SPI-owned access
  assign w_host_win = host_req & ~r_lock &
                      (~w_pend | (r_owner == OWN_SPI));

  always_comb begin
    w_next     = r_state;
    w_owner_nx = r_owner;
    w_lock_nx  = r_lock;
    w_timer_nx = r_timer;
    w_pop      = 1'b0;
    w_din      = '0;
    w_vld      = 1'b0;
    w_gnt      = 1'b0;
    w_spi_cap  = 1'b0;
    w_host_cap = 1'b0;
    w_to       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_host_win)
          w_next = S_H_ADDR;
        else if (w_pend)
          w_next = S_SPI_ISSUE;
      end
      S_SPI_ISSUE: begin
        w_din      = w_buf;
        w_vld      = 1'b1;
        w_pop      = 1'b1;
        w_owner_nx = OWN_SPI;
        w_timer_nx = '0;
        case (w_buf[9:8])
          CMD_WR_ADDR, CMD_RD_ADDR: begin
            w_lock_nx = 1'b1;
            w_next    = S_SPI_LOCK;
          end
          CMD_WR_DATA: begin
            w_lock_nx = 1'b0;
            w_next    = S_IDLE;
          end
          default: w_next = S_SPI_RD_WAIT;
        endcase
      end
      S_SPI_LOCK: begin
        if (w_pend) begin
          w_next = S_SPI_ISSUE;
        end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
          w_lock_nx = 1'b0;
          w_to      = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      S_SPI_RD_WAIT: begin
        if (ram_tx_valid) begin
          w_spi_cap = 1'b1;
          w_lock_nx = 1'b0;
          w_next    = S_IDLE;
        end else if (r_timer == TW'(RD_TIMEOUT - 1)) begin
          w_to      = 1'b1;
          w_lock_nx = 1'b0;
          w_next    = S_IDLE;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      S_H_ADDR: begin
        w_gnt      = 1'b1;
        w_vld      = 1'b1;
        w_owner_nx = OWN_HOST;
        w_din      = mk_cmd(host_we ? CMD_WR_ADDR : CMD_RD_ADDR,
                            8'(host_addr));
        w_next     = S_H_DATA;
      end
      S_H_DATA: begin
        w_vld      = 1'b1;
        w_timer_nx = '0;
        w_din      = r_we ? mk_cmd(CMD_WR_DATA, 8'(r_wdata))
                          : mk_cmd(CMD_RD_DATA, 8'h00);
        w_next     = r_we ? S_IDLE : S_H_RD_WAIT;
      end
      S_H_RD_WAIT: begin
        if (ram_tx_valid) begin
          w_host_cap = 1'b1;
          w_next     = S_IDLE;
        end else if (r_timer == TW'(RD_TIMEOUT - 1)) begin
          w_to   = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_owner        <= OWN_SPI;
      r_lock         <= 1'b0;
      r_timer        <= '0;
      r_we           <= 1'b0;
      r_wdata        <= '0;
      r_spi_tx_data  <= '0;
      r_spi_tx_valid <= 1'b0;
      r_host_rdata   <= '0;
      r_host_rvalid  <= 1'b0;
      r_err_to       <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_owner       <= w_owner_nx;
      r_lock        <= w_lock_nx;
      r_timer       <= w_timer_nx;
      r_host_rvalid <= w_host_cap;
      r_err_to      <= r_err_to | w_to;
      if (w_gnt) begin
        r_we    <= host_we;
        r_wdata <= host_wdata;
      end
      // fresh read data beats a deselect in the same cycle
      if (w_spi_cap) begin
        r_spi_tx_data  <= ram_dout;
        r_spi_tx_valid <= 1'b1;
      end else if (spi_ss_n) begin
        r_spi_tx_valid <= 1'b0;
      end
      if (w_host_cap)
        r_host_rdata <= ram_dout;
    end
  end

  assign ram_din      = w_din;
  assign ram_rx_valid = w_vld;
  assign host_gnt     = w_gnt;
  assign spi_tx_data  = r_spi_tx_data;
  assign spi_tx_valid = r_spi_tx_valid;
  assign host_rdata   = r_host_rdata;
  assign host_rvalid  = r_host_rvalid;
  assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter with a small RAM
// responder; expected commands and read data are queued.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic       spi_ss_n;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid = 1'b0;
  logic       err_ovf;
  logic       err_timeout;

  always #5 clk = ~clk;

  spi_ram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_ss_n     (spi_ss_n),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .err_ovf      (err_ovf),
    .err_timeout  (err_timeout)
  );

  logic [31:0] outs;
  assign outs = {spi_tx_data, spi_tx_valid, host_gnt,
                 host_rdata, host_rvalid, ram_din,
                 ram_rx_valid, err_ovf, err_timeout};

  // RAM responder: read data one cycle after RD_DATA
  logic [7:0] mem [256];
  logic [7:0] ra = 8'h00;
  bit         suppress = 1'b0;

  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ra = ram_din[7:0];
        2'b01: mem[ra] = ram_din[7:0];
        default: if (!suppress) begin
          ram_tx_valid <= 1'b1;
          ram_dout     <= mem[ra];
        end
      endcase
    end
  end

  logic [9:0] q_cmd[$];
  logic [7:0] q_spi[$];
  logic [7:0] q_host[$];
  int n_vec = 0;
  int n_err = 0;
  int gnt_cnt = 0;
  int rv_cnt = 0;
  logic prev_tx = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_rx_valid) begin
        if (q_cmd.size() == 0)
          fail("ram_cmd", $sformatf("got %0h expected none", ram_din));
        else
          check("ram_cmd", 32'(ram_din), 32'(q_cmd.pop_front()));
      end
      if (host_gnt) gnt_cnt++;
      if (host_rvalid) begin
        rv_cnt++;
        if (q_host.size() == 0)
          fail("host_rdata", $sformatf("got %0h expected none", host_rdata));
        else
          check("host_rdata", 32'(host_rdata), 32'(q_host.pop_front()));
      end
      if (spi_tx_valid && !prev_tx) begin
        if (q_spi.size() == 0)
          fail("spi_tx_data", $sformatf("got %0h expected none", spi_tx_data));
        else
          check("spi_tx_data", 32'(spi_tx_data), 32'(q_spi.pop_front()));
      end
      prev_tx = spi_tx_valid;
    end
  end

  task automatic send_spi(input logic [9:0] c);
    @(negedge clk);
    spi_rx_data  = c;
    spi_rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    spi_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic host_txn(input logic we,
                          input logic [7:0] a,
                          input logic [7:0] d);
    int k;
    @(negedge clk);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!host_gnt && k < 300);
    if (!host_gnt)
      fail("host_gnt_wait", "got no grant expected grant within 300 cycles");
    host_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by 2000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g0;
    int rv0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    spi_rx_data = '0;
    spi_rx_valid = 1'b0;
    spi_ss_n = 1'b0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    #1;
    check("reset_outputs", outs, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // SPI write pair with latency check
    q_cmd.push_back(10'h02A);
    @(negedge clk);
    spi_rx_data  = 10'h02A;
    spi_rx_valid = 1'b1;
    @(posedge clk);
    #1 check("latency_t1", 32'(ram_rx_valid), 32'h0);
    @(posedge clk);
    #1 check("latency_t2", 32'(ram_rx_valid), 32'h1);
    @(negedge clk);
    @(negedge clk);
    spi_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    q_cmd.push_back(10'h15C);
    send_spi(10'h15C);
    check("mem_2A", 32'(mem[8'h2A]), 32'h5C);

    // SPI read, held until deselect
    q_cmd.push_back(10'h22A);
    q_cmd.push_back(10'h300);
    q_spi.push_back(8'h5C);
    send_spi(10'h22A);
    send_spi(10'h300);
    repeat (4) @(negedge clk);
    check("spi_tx_hold_valid", 32'(spi_tx_valid), 32'h1);
    check("spi_tx_hold_data", 32'(spi_tx_data), 32'h5C);
    spi_ss_n = 1'b1;
    repeat (2) @(negedge clk);
    check("spi_tx_release", 32'(spi_tx_valid), 32'h0);
    spi_ss_n = 1'b0;

    // lock protection
    q_cmd.push_back(10'h010);
    send_spi(10'h010);
    q_cmd.push_back(10'h133);
    q_cmd.push_back(10'h010);
    q_cmd.push_back(10'h1FF);
    g0 = gnt_cnt;
    fork
      host_txn(1'b1, 8'h10, 8'hFF);
      begin
        repeat (8) @(negedge clk);
        check("no_gnt_under_lock", 32'(gnt_cnt - g0), 32'h0);
        send_spi(10'h133);
      end
    join
    repeat (3) @(negedge clk);
    check("mem_10", 32'(mem[8'h10]), 32'hFF);

    // fairness after an SPI-owned access
    q_cmd.push_back(10'h177);
    send_spi(10'h177);
    q_cmd.push_back(10'h22A);
    q_cmd.push_back(10'h300);
    q_host.push_back(8'h5C);
    q_cmd.push_back(10'h044);
    fork
      begin
        @(negedge clk);
        spi_rx_data  = 10'h044;
        spi_rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        spi_rx_valid = 1'b0;
      end
      begin
        @(negedge clk);
        host_txn(1'b0, 8'h2A, 8'h00);
      end
    join
    repeat (8) @(negedge clk);
    q_cmd.push_back(10'h166);
    send_spi(10'h166);
    check("no_ovf", 32'(err_ovf), 32'h0);
    check("no_timeout_yet", 32'(err_timeout), 32'h0);

    // lock timeout releases to a waiting host
    q_cmd.push_back(10'h205);
    send_spi(10'h205);
    q_cmd.push_back(10'h005);
    q_cmd.push_back(10'h1AB);
    host_we    = 1'b1;
    host_addr  = 8'h05;
    host_wdata = 8'hAB;
    host_req   = 1'b1;
    k = 0;
    while (!err_timeout && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("lock_timeout_flag", 32'(err_timeout), 32'h1);
    check("lock_timeout_window", 32'(k >= 58 && k <= 66), 32'h1);
    @(negedge clk);
    check("gnt_after_timeout", 32'(host_gnt), 32'h1);
    host_req = 1'b0;
    repeat (3) @(negedge clk);
    check("mem_05", 32'(mem[8'h05]), 32'hAB);

    // async reset while waiting on a host read
    suppress = 1'b1;
    q_cmd.push_back(10'h22A);
    q_cmd.push_back(10'h300);
    host_txn(1'b0, 8'h2A, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", outs, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    suppress = 1'b0;
    q_cmd.push_back(10'h001);
    send_spi(10'h001);
    q_cmd.push_back(10'h102);
    send_spi(10'h102);
    check("err_after_reset", 32'(err_timeout), 32'h0);

    // host read timeout with an SPI overwrite while busy
    suppress = 1'b1;
    q_cmd.push_back(10'h220);
    q_cmd.push_back(10'h300);
    q_cmd.push_back(10'h199);
    rv0 = rv_cnt;
    host_txn(1'b0, 8'h20, 8'h00);
    @(negedge clk);
    spi_rx_data  = 10'h055;
    spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    @(negedge clk);
    spi_rx_data  = 10'h199;
    spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    repeat (8) @(negedge clk);
    suppress = 1'b0;
    check("host_rd_timeout", 32'(err_timeout), 32'h1);
    check("no_host_rvalid", 32'(rv_cnt - rv0), 32'h0);
    check("ovf_flag", 32'(err_ovf), 32'h1);

    repeat (5) @(negedge clk);
    check("cmd_queue_drained", 32'(q_cmd.size()), 32'h0);
    check("spi_queue_drained", 32'(q_spi.size()), 32'h0);
    check("host_queue_drained", 32'(q_host.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Shares the single-port RAM between two requesters: the SPI slave command stream and a local host port (BIST/scrub/debug).
- Forwards 10-bit SPI commands to the RAM as single-cycle strobes.
- Issues host reads/writes as atomic two-command pairs.
- Routes RAM read data back to whichever requester issued the read.
- Sits between the SPI slave and the RAM inside the SPI-RAM wrapper.

Parameters:
ADDR_SIZE, 8, RAM address width; also the width of the host address.
MEM_WIDTH, 8, RAM data width.
LOCK_TIMEOUT, 64, idle cycles after which an unpaired SPI address command releases the RAM lock.
RD_TIMEOUT, 4, cycles to wait for ram_tx_valid after a read command.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
spi_rx_data  in  10  command from SPI slave; [9:8]=opcode, [7:0]=payload.
spi_rx_valid  in  1  level from SPI slave; stays high for several cycles per frame.
spi_ss_n  in  1  SPI chip select, active low.
spi_tx_data  out  MEM_WIDTH  read data to SPI slave.
spi_tx_valid  out  1  read data valid to SPI slave.
host_req  in  1  host request; held until host_gnt.
host_we  in  1  1=write, 0=read.
host_addr  in  ADDR_SIZE  host address.
host_wdata  in  MEM_WIDTH  host write data.
host_gnt  out  1  one-cycle accept pulse.
host_rdata  out  MEM_WIDTH  host read data.
host_rvalid  out  1  one-cycle pulse when host_rdata is valid.
ram_din  out  10  command to RAM.
ram_rx_valid  out  1  one-cycle command strobe to RAM.
ram_dout  in  MEM_WIDTH  RAM read data.
ram_tx_valid  in  1  RAM read-data valid.
err_ovf  out  1  sticky: SPI command overwritten while pending.
err_timeout  out  1  sticky: read timeout or lock timeout occurred.

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; SPI buffer empty; lock clear; timers 0. Reset mid-transaction abandons it with no RAM strobe.
- Opcodes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- SPI capture:
  - A rising edge of spi_rx_valid (registered previous value 0, current 1) loads spi_rx_data into a 1-entry buffer and sets spi_pend.
  - Edge while spi_pend=1: overwrite the buffer and set err_ovf.
  - Continued high level of spi_rx_valid is ignored.
- ram_rx_valid is high exactly one cycle per command; ram_din is only meaningful that cycle.
- FSM states: IDLE, SPI_ISSUE, SPI_LOCK, SPI_RD_WAIT, H_ADDR, H_DATA, H_RD_WAIT.
- IDLE arbitration:
  - spi_pend has priority, except when last_owner=SPI and host_req=1; then host wins (alternation).
  - Never grant host while lock=1.
- SPI_ISSUE:
  - Drive ram_din=buffer, ram_rx_valid=1, clear spi_pend, last_owner=SPI.
  - Opcode 00/10: set lock, go to SPI_LOCK.
  - Opcode 01: clear lock, go to IDLE.
  - Opcode 11: go to SPI_RD_WAIT.
- Latency: first spi_rx_valid high sample at cycle t gives ram_rx_valid at t+2 when the arbiter is idle.
- SPI_LOCK:
  - Count idle cycles.
  - spi_pend goes to SPI_ISSUE (any opcode accepted; a repeated 00/10 restarts the count).
  - Count reaching LOCK_TIMEOUT: clear lock, set err_timeout, go to IDLE.
- SPI_RD_WAIT:
  - First cycle with ram_tx_valid=1: capture ram_dout into spi_tx_data, set spi_tx_valid, clear lock, go to IDLE.
  - RD_TIMEOUT cycles without ram_tx_valid: set err_timeout, clear lock, go to IDLE.
- spi_tx_valid / spi_tx_data: held stable until spi_ss_n is sampled high, then spi_tx_valid=0.
- Host write:
  - H_ADDR: pulse host_gnt, issue {00,host_addr}, latch host_wdata.
  - H_DATA: issue {01,wdata}, go to IDLE.
  - Two strobes on consecutive cycles.
- Host read:
  - H_ADDR: gnt, issue {10,addr}.
  - H_DATA: issue {11,8'h00}.
  - H_RD_WAIT: first ram_tx_valid gives host_rdata=ram_dout and a host_rvalid pulse; timeout gives err_timeout, no rvalid.
  - last_owner=HOST.
- An SPI edge during a host transaction is buffered and served afterwards; the RAM is never interleaved mid-pair.
- Simultaneous spi_ss_n rise and a new read return: the new data wins; spi_tx_valid stays 1.

Decomposition:
- Package spi_ram_arb_pkg:
  - state enum;
  - opcode localparams CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA;
  - owner enum {OWN_SPI, OWN_HOST}.
- Sub-module spi_cmd_capture: edge detect + 1-entry buffer + err_ovf; interface load/pop/pend/data.

Test Plan:
- SPI write pair:
  - spi_rx_valid high 3 cycles with 10'h0_2A, then 10'h1_5C → ram_rx_valid single pulses with ram_din 10'h02A then 10'h15C.
  - First pulse arrives 2 cycles after rise; RAM[0x2A]=0x5C.
- SPI read:
  - Send 10'h2_2A, then 10'h3_00; RAM returns 0x5C → spi_tx_valid=1 and spi_tx_data=0x5C, held until spi_ss_n rises.
- Lock protection:
  - SPI 10'h0_10, then host_req write addr 0x10 data 0xFF before the SPI data frame → no host_gnt until SPI 10'h1_33 is issued.
  - Then the host pair issues and RAM[0x10]=0xFF.
- Fairness:
  - host_req and SPI pending simultaneously after an SPI-owned transaction → host granted first, then the SPI command issues.
- Timeouts:
  - SPI 10'h2_05 with no follow-up for 64 cycles → lock cleared, err_timeout=1, host granted next cycle.
  - RAM never asserts ram_tx_valid on a host read → err_timeout after 4 cycles, no host_rvalid.
- Async reset:
  - Assert rst in H_RD_WAIT → all outputs 0 immediately, with no clock edge needed.
  - After release, SPI 10'h0_01 issues normally.
